// File: rtl/glitch_pkg.sv
// Shared constants for the glitch filter: FSM state encodings and parameter defaults.
package glitch_pkg;

  localparam logic [0:0] ST_STABLE  = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  localparam int DEF_STABLE_CYCLES = 3;
  localparam int DEF_CNT_W         = 8;

endpackage

// File: rtl/glitch_filter_sync2.sv
// Two-flop synchronizer (module sync2) for a single asynchronous bit.
module sync2 #(
  parameter bit RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_reg <= {2{RESET_VAL}};
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/glitch_filter.sv
// Glitch filter: synchronizes din and accepts a level change only after STABLE_CYCLES
// consecutive differing samples. Optional glitch_width output under macro GLITCH_WIDTH_EN.
module glitch_filter
  import glitch_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             clear_count,
  output logic             dout,
  output logic             glitch,
  output logic [CNT_W-1:0] glitch_count
`ifdef GLITCH_WIDTH_EN
  ,
  output logic [CNT_W-1:0] glitch_width
`endif
);

  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] COUNT_MAX = {CNT_W{1'b1}};

  logic             din_s;
  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] run_cnt_reg, run_cnt_next;
  logic             dout_reg, dout_next;
  logic             glitch_reg, glitch_next;
  logic [CNT_W-1:0] count_reg, count_next;

  sync2 #(
    .RESET_VAL(RESET_LEVEL)
  ) u_sync2 (
    .clk(clk),
    .rst(rst),
    .d  (din),
    .q  (din_s)
  );

  always_comb begin
    state_next   = state_reg;
    run_cnt_next = run_cnt_reg;
    dout_next    = dout_reg;
    glitch_next  = 1'b0;
    count_next   = count_reg;

    case (state_reg)
      ST_STABLE: begin
        if (din_s != dout_reg) begin
          state_next   = ST_PENDING;
          run_cnt_next = CNT_W'(1);
        end else begin
          run_cnt_next = '0;
        end
      end
      ST_PENDING: begin
        if (din_s == dout_reg) begin
          // Input fell back before the run completed: reject it as a glitch.
          glitch_next  = 1'b1;
          state_next   = ST_STABLE;
          run_cnt_next = '0;
        end else if (run_cnt_reg == RUN_LAST) begin
          dout_next    = din_s;
          state_next   = ST_STABLE;
          run_cnt_next = '0;
        end else begin
          run_cnt_next = run_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next   = ST_STABLE;
        run_cnt_next = '0;
      end
    endcase

    // A clear coinciding with a glitch restarts at 1 so that glitch is not lost.
    if (glitch_next) begin
      if (clear_count) begin
        count_next = CNT_W'(1);
      end else if (count_reg != COUNT_MAX) begin
        count_next = count_reg + 1'b1;
      end
    end else if (clear_count) begin
      count_next = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_STABLE;
      run_cnt_reg <= '0;
      dout_reg    <= RESET_LEVEL;
      glitch_reg  <= 1'b0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      run_cnt_reg <= run_cnt_next;
      dout_reg    <= dout_next;
      glitch_reg  <= glitch_next;
      count_reg   <= count_next;
    end
  end

`ifdef GLITCH_WIDTH_EN
  logic [CNT_W-1:0] width_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      width_reg <= '0;
    end else if (glitch_next) begin
      width_reg <= run_cnt_reg;
    end
  end

  assign glitch_width = width_reg;
`endif

  assign dout         = dout_reg;
  assign glitch       = glitch_reg;
  assign glitch_count = count_reg;

endmodule

// File: doc/glitch_filter.md
GLITCH_FILTER -- requirements
Module: glitch_filter

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 3: consecutive differing samples needed to accept a level change; legal range 2..2^CNT_W-1.
REQ-002 SHALL have parameter CNT_W, default 8: width of glitch_count and glitch_width.
REQ-003 SHALL have parameter RESET_LEVEL, default 0: level of dout and the synchronizer flops after reset.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 din  input  1  asynchronous, possibly glitchy signal, e.g. the output of a hazard-prone combinational path.
REQ-007 clear_count  input  1  synchronous clear of glitch_count.
REQ-008 dout  output  1  filtered, registered level.
REQ-009 glitch  output  1  one-cycle strobe per rejected pulse.
REQ-010 glitch_count  output  CNT_W  saturating count of rejected pulses.
REQ-011 glitch_width  output  CNT_W  width in samples of the last rejected pulse; present only with GLITCH_WIDTH_EN.

Function
REQ-012 din SHALL pass through a two-flop synchronizer; its second-stage output is din_s.
REQ-013 The FSM SHALL have two states: STABLE and PENDING, plus a run counter run_cnt.
REQ-014 STABLE, din_s == dout: stay in STABLE with run_cnt = 0.
REQ-015 STABLE, din_s != dout: go to PENDING with run_cnt = 1.
REQ-016 PENDING, din_s != dout, run_cnt < STABLE_CYCLES-1: run_cnt increments.
REQ-017 PENDING, din_s != dout, run_cnt == STABLE_CYCLES-1: dout <= din_s, go to STABLE, run_cnt = 0; no glitch.
REQ-018 PENDING, din_s == dout: glitch = 1 for exactly one cycle, glitch_width <= run_cnt, glitch_count increments, go to STABLE; dout unchanged.
REQ-019 Accepted-edge latency SHALL be STABLE_CYCLES+1 edges after the first edge that captures the new din level.
REQ-020 glitch_count SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 clear_count without glitch: glitch_count <= 0.
REQ-022 clear_count in the same cycle as glitch: glitch_count <= 1, so no glitch is lost.
REQ-023 glitch SHALL be 0 in every cycle not named in REQ-018.
REQ-024 All outputs SHALL be registered, with no combinational path from din or clear_count.

Reset
REQ-025 When rst = 1 at an edge, reset SHALL take priority over all other events.
REQ-026 Reset values: dout = RESET_LEVEL, both synchronizer flops = RESET_LEVEL, state = STABLE, run_cnt = 0, glitch = 0, glitch_count = 0, glitch_width = 0.
REQ-027 Reset in PENDING SHALL abort the pending run with no glitch strobe and no count.

Configuration
REQ-028 Macro GLITCH_WIDTH_EN defined: glitch_width port and register SHALL exist and update per REQ-018.
REQ-029 Macro GLITCH_WIDTH_EN undefined: the glitch_width port and register SHALL be absent, and all other behaviour is identical.

Structure
REQ-030 Shared package glitch_pkg SHALL hold the state encodings ST_STABLE/ST_PENDING and the default values of STABLE_CYCLES and CNT_W.
REQ-031 The synchronizer SHALL be a separate sub-module sync2, with 1-bit data, reset value as a parameter, and the same clk/rst.
REQ-032 The FSM, run counter and statistics SHALL reside in glitch_filter.

Verification (STABLE_CYCLES=3, CNT_W=8, RESET_LEVEL=0, GLITCH_WIDTH_EN defined)
REQ-033 Reset for 2 cycles, din=1 -> dout=0, glitch=0, glitch_count=0, glitch_width=0.
REQ-034 din 0->1, captured at edge n and held 10 cycles -> dout=1 after edge n+4; glitch never asserts; glitch_count=0.
REQ-035 din=1 captured at edges n and n+1, 0 from n+2 -> glitch=1 for one cycle after edge n+4; glitch_width=2; glitch_count=1; dout stays 0.
REQ-036 300 one-cycle din pulses separated by 6 low cycles -> each rejected pulse gives glitch_width=1; glitch_count=255 and holds there (saturated).
REQ-037 clear_count=1 in the same cycle as a glitch strobe, with count at 5 -> glitch_count=1; clear_count alone on the next cycle -> 0.
REQ-038 rst asserted while in PENDING with run_cnt=2 -> no glitch strobe, dout=0, state STABLE, glitch_count unchanged at 0.
